// File: rtl/cla_seq_adder_pkg.sv
// Shared types and default sizing for the sequential carry-lookahead adder.
package cla_seq_adder_pkg;

    localparam int unsigned DEF_SLICE_W    = 8;
    localparam int unsigned DEF_NUM_SLICES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice index width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE_W-bit carry-lookahead slice: full lookahead carries plus block propagate.
module cla_slice #(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               block_p
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened lookahead sum of products, not a ripple chain.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(SLICE_W); i++) begin
            logic acc;
            logic prod;
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & cin);
        end
    end

    assign sum     = p ^ c[SLICE_W-1:0];
    assign cout    = c[SLICE_W];
    assign block_p = &p;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one CLA slice reused NUM_SLICES times, valid/ready on both sides.
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int unsigned SLICE_W    = DEF_SLICE_W,
    parameter int unsigned NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_b,
    input  logic                          carry_in,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          carry_out,
    output logic                          group_propagate,
    output logic                          busy
);

    localparam int unsigned IDX_W = idx_width(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef logic [NUM_SLICES-1:0][SLICE_W-1:0] word_t;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    word_t             a_q, a_d;
    word_t             b_q, b_d;
    word_t             sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              gp_acc_q, gp_acc_d;
    logic              carry_out_q, carry_out_d;
    logic              gp_out_q, gp_out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_p;
    logic               accept;

    cla_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a       (a_q[idx_q]),
        .b       (b_q[idx_q]),
        .cin     (carry_q),
        .sum     (slice_sum),
        .cout    (slice_cout),
        .block_p (slice_p)
    );

    // Ready is combinational so a held result can be swapped for a new op with no bubble.
    assign in_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // Next-state and next-register logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        gp_acc_d    = gp_acc_q;
        carry_out_d = carry_out_q;
        gp_out_d    = gp_out_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
            end
            RUN: begin
                out_valid_d       = 1'b0;
                sum_d[idx_q]      = slice_sum;
                carry_d           = slice_cout;
                gp_acc_d          = gp_acc_q & slice_p;
                idx_d             = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    carry_out_d = slice_cout;
                    gp_out_d    = gp_acc_q & slice_p;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Accept already excludes flush and RUN, so it can override the case above.
        if (accept) begin
            state_d     = RUN;
            a_d         = op_a;
            b_d         = op_b;
            carry_d     = carry_in;
            idx_d       = '0;
            gp_acc_d    = 1'b1;
            out_valid_d = 1'b0;
        end

        if (flush) begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            gp_acc_q    <= 1'b0;
            carry_out_q <= 1'b0;
            gp_out_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            gp_acc_q    <= gp_acc_d;
            carry_out_q <= carry_out_d;
            gp_out_q    <= gp_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sum             = sum_q;
    assign carry_out       = carry_out_q;
    assign group_propagate = gp_out_q;
    assign out_valid       = out_valid_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed scoreboard bench for cla_seq_adder at the default 4x8-bit configuration.
module tb_cla_seq_adder;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         gp;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         group_propagate;
    logic         busy;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    cla_seq_adder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .carry_in        (carry_in),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .sum             (sum),
        .carry_out       (carry_out),
        .group_propagate (group_propagate),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t        e;
        logic [W:0]  full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s  = full[W-1:0];
        e.co = full[W];
        e.gp = &(a ^ b);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        carry_in = c;
        sb.push_back(model(a, b, c));
    endtask

    // Counts edges after the accept edge until out_valid; drives junk in_valid meanwhile.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin
            in_valid = 1'b1;
            op_a     = 32'hDEAD_BEEF;
            op_b     = 32'hCAFE_F00D;
            step();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 64'(sum), 64'(e.s));
            check({tag, "_cout"}, 64'(carry_out), 64'(e.co));
            check({tag, "_gp"}, 64'(group_propagate), 64'(e.gp));
        end
    endtask

    task automatic consume(input string tag);
        compare_head(tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_idle_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        present(a, b, c);
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        step();
        check({tag, "_busy"}, 64'(busy), 64'(1));
        wait_result(tag, 4);
        consume(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op_a        = '0;
        op_b        = '0;
        carry_in    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        // Reset held with no clock edge yet.
        #2;
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_flags", 64'({carry_out, group_propagate, out_valid, busy}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 64'(busy), 64'(0));

        run_op("ovf", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("mix", 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        run_op("allp", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0);
        run_op("allp_cin", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
        run_op("zero", 32'h0000_0000, 32'h0000_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
        end

        // Backpressure, then back-to-back accept on the releasing handshake.
        present(32'h8000_0000, 32'h8000_0000, 1'b1);
        step();
        wait_result("bp1", 4);
        for (int i = 0; i < 10; i++) begin
            check("bp_sum_hold", 64'(sum), 64'(sb[0].s));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_valid_hold", 64'(out_valid), 64'(1));
            step();
        end
        compare_head("bp1");
        out_ready = 1'b1;
        present(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'(1));
        step();
        out_ready = 1'b0;
        check("b2b_valid_low", 64'(out_valid), 64'(0));
        check("b2b_busy", 64'(busy), 64'(1));
        wait_result("b2b", 4);
        consume("b2b");

        // Flush at idx=2.
        present(32'h1111_1111, 32'h2222_2222, 1'b0);
        void'(sb.pop_back());
        step();
        in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 6; i++) begin
            check("flush_no_valid", 64'(out_valid), 64'(0));
            step();
        end
        run_op("post_flush", 32'h0000_0001, 32'h0000_0001, 1'b0);

        // Asynchronous reset mid-RUN.
        present(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        void'(sb.pop_back());
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum", 64'(sum), 64'(0));
        check("arst_flags", 64'({carry_out, group_propagate, out_valid, busy}), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("arst_no_valid", 64'(out_valid), 64'(0));
        end
        run_op("post_arst", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
